// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants, FSM state type and digit-count helper for the
// sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

   // Width of one packed BCD digit.
   localparam int unsigned BCD_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   // Smallest digit count whose decimal range covers 2^bin_w - 1.
   function automatic int unsigned min_digits(input int unsigned bin_w);
      longint unsigned max_v;
      longint unsigned pow;
      int unsigned     d;
      if (bin_w >= 64) begin
         return 20;
      end
      max_v = (64'd1 << bin_w) - 64'd1;
      pow   = 64'd1;
      d     = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         if (pow <= max_v) begin
            pow = pow * 64'd10;
            d   = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single-digit double-dabble correction: adds 3 to a digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_add3
   import bin2bcd_seq_pkg::*;
(
   input  logic [BCD_W-1:0] i_d,
   output logic [BCD_W-1:0] o_q
);

   // Conditional add-3 on one BCD digit.
   always_comb begin
      o_q = i_d;
      if (i_d >= BCD_W'(5)) begin
         o_q = i_d + BCD_W'(3);
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3). One bit of the operand
// is shifted into the BCD scratch per cycle; the result and a leading-zero
// mask are committed together with a one-cycle done pulse and then held.
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int unsigned BIN_W  = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [BIN_W-1:0]        bin_in,
   output logic                    busy,
   output logic                    done,
   output logic [BCD_W*DIGITS-1:0] bcd_out,
   output logic [DIGITS-1:0]       digit_valid
);

   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam int unsigned ACC_W = BCD_W * DIGITS;

   // Elaboration-time parameter sanity checks.
   if (BIN_W < 4) begin : g_chk_bin_w
      $fatal(1, "bin2bcd_seq: BIN_W must be at least 4");
   end
   if (DIGITS < min_digits(BIN_W)) begin : g_chk_digits
      $fatal(1, "bin2bcd_seq: DIGITS too small for BIN_W");
   end

   state_t             r_state;
   logic [BIN_W-1:0]   r_sr;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [ACC_W-1:0]   r_bcd;
   logic [DIGITS-1:0]  r_dv;

   logic [ACC_W-1:0]   w_acc_adj;
   logic [ACC_W-1:0]   w_acc_next;
   logic [DIGITS-1:0]  w_dv;
   logic               w_any;

   // Per-digit add-3 correction of the scratch accumulator.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .i_d (r_acc[g*BCD_W +: BCD_W]),
         .o_q (w_acc_adj[g*BCD_W +: BCD_W])
      );
   end

   // Corrected accumulator shifted left with the operand MSB entering bit 0.
   always_comb begin
      w_acc_next = {w_acc_adj[ACC_W-2:0], r_sr[BIN_W-1]};
   end

   // Leading-zero mask: digit k is significant if any digit at or above it is nonzero.
   always_comb begin
      w_dv  = '0;
      w_any = 1'b0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         w_any = w_any | (w_acc_next[(DIGITS-1-k)*BCD_W +: BCD_W] != '0);
         w_dv[DIGITS-1-k] = w_any;
      end
      w_dv[0] = 1'b1;
   end

   // Control FSM with counter, scratch and registered outputs.
   // The result is committed on the final shift edge (entering DONE) so that
   // bcd_out/digit_valid change in the same cycle that done is high.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_sr    <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_bcd   <= '0;
         r_dv    <= DIGITS'(1);
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_sr    <= bin_in;
                  r_acc   <= '0;
                  r_cnt   <= CNT_W'(BIN_W);
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_acc <= w_acc_next;
               r_sr  <= {r_sr[BIN_W-2:0], 1'b0};
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_bcd   <= w_acc_next;
                  r_dv    <= w_dv;
               end
            end
            ST_DONE: begin
               if (start) begin
                  r_sr    <= bin_in;
                  r_acc   <= '0;
                  r_cnt   <= CNT_W'(BIN_W);
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign bcd_out     = r_bcd;
   assign digit_valid = r_dv;

endmodule
